log2_seq: RTL and testbench

//   Multi-cycle floor(log2) unit with valid/ready handshake on both sides; generalises the
//   8-bit one-hot combinational log to any power-of-two width W and arbitrary (non-one-hot) input.

---
 rtl/log2_pkg.sv | 17 +
 rtl/log2_step.sv | 31 +++
 rtl/log2_seq.sv | 102 ++++++++++
 tb/tb_log2_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/log2_pkg.sv
// rtl/log2_pkg.sv - shared state encoding, result constants and width helper for the log2 unit
package log2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } log2_state_t;

   // Slice to OW bits for the all-ones (-1) result reported for a zero operand.
   localparam logic [31:0] LOG2_ZERO_RES = '1;

   function automatic int log2_ow(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/log2_step.sv
// rtl/log2_step.sv - one binary-search step of floor(log2): try a shift of 2^k,
// keep it and set result bit k if anything remains
module log2_step
   import log2_pkg::*;
#(
   parameter int W  = 32,
   parameter int LW = $clog2(W),
   parameter int KW = (LW > 1) ? $clog2(LW) : 1
) (
   input  logic [W-1:0]  v,
   input  logic [LW-1:0] r,
   input  logic [KW-1:0] k,
   output logic [W-1:0]  v_nxt,
   output logic [LW-1:0] r_nxt
);

   logic [LW-1:0] sh;
   logic [W-1:0]  vs;

   always_comb begin
      sh    = LW'(1) << k;
      vs    = v >> sh;
      v_nxt = v;
      r_nxt = r;
      if (vs != '0) begin
         v_nxt = vs;
         r_nxt = r | (LW'(1) << k);
      end
   end

endmodule

// File: rtl/log2_seq.sv
// rtl/log2_seq.sv - multi-cycle floor(log2) with valid/ready on both sides, one search step per clock;
// define LOG2_EXACT_EN to add the out_exact (power-of-two) flag
module log2_seq
   import log2_pkg::*;
#(
   parameter  int W  = 32,
   localparam int LW = $clog2(W),
   localparam int OW = log2_ow(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_zero
`ifdef LOG2_EXACT_EN
   ,
   output logic          out_exact
`endif
);

   localparam int KW = (LW > 1) ? $clog2(LW) : 1;

   log2_state_t   state, state_nxt;
   logic [W-1:0]  v, v_nxt;
   logic [LW-1:0] r, r_nxt;
   logic [KW-1:0] k;

   log2_step #(.W(W), .LW(LW), .KW(KW)) u_step (
      .v     (v),
      .r     (r),
      .k     (k),
      .v_nxt (v_nxt),
      .r_nxt (r_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (in_data == '0) ? ST_DONE : ST_CALC;
         end
         ST_CALC: begin
            if (k == '0) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Search walks k from LW-1 down to 0; the single step instance is reused every CALC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v        <= '0;
         r        <= '0;
         k        <= '0;
         out_data <= '0;
         out_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (in_valid) begin
               v        <= in_data;
               r        <= '0;
               k        <= KW'(LW - 1);
               out_zero <= (in_data == '0);
               if (in_data == '0) out_data <= LOG2_ZERO_RES[OW-1:0];
            end
            ST_CALC: begin
               v <= v_nxt;
               r <= r_nxt;
               k <= k - KW'(1);
               if (k == '0) out_data <= {1'b0, r_nxt};
            end
            default: ;
         endcase
      end
   end

`ifdef LOG2_EXACT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out_exact <= 1'b0;
      else if (state == ST_IDLE && in_valid)
         out_exact <= (in_data != '0) && ((in_data & (in_data - W'(1))) == '0);
   end
`endif

endmodule

// File: tb/tb_log2_seq.sv
// tb/tb_log2_seq.sv - directed and random checks of log2_seq at W=8 and W=32 (LOG2_EXACT_EN aware)
module tb_log2_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       iv8, ir8, ov8, or8, oz8;
   logic [7:0] id8;
   logic [3:0] od8;

   logic        iv32, ir32, ov32, or32, oz32;
   logic [31:0] id32;
   logic [5:0]  od32;

`ifdef LOG2_EXACT_EN
   logic ox8, ox32;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   log2_seq #(.W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .in_data   (id8),
      .in_ready  (ir8),
      .out_valid (ov8),
      .out_ready (or8),
      .out_data  (od8),
      .out_zero  (oz8)
`ifdef LOG2_EXACT_EN
      ,
      .out_exact (ox8)
`endif
   );

   log2_seq #(.W(32)) u_dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv32),
      .in_data   (id32),
      .in_ready  (ir32),
      .out_valid (ov32),
      .out_ready (or32),
      .out_data  (od32),
      .out_zero  (oz32)
`ifdef LOG2_EXACT_EN
      ,
      .out_exact (ox32)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] model32(input logic [31:0] x);
      logic [6:0] res;
      res = {1'b1, 6'h3F};
      for (int i = 0; i < 32; i++)
         if (x[i]) res = {1'b0, 6'(i)};
      return res;
   endfunction

   // Latency counts rising edges from the accept edge (inclusive) to out_valid.
   task automatic op8(input logic [7:0] x, input logic [3:0] ed, input logic ez, input int el);
      int lat;
      @(negedge clk);
      iv8 = 1'b1;
      id8 = x;
      #1 chk("in_ready8", ir8, 1);
      @(posedge clk);
      lat = 1;
      #1 iv8 = 1'b0;
      while (!ov8 && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("lat8", lat, el);
      chk("data8", od8, ed);
      chk("zero8", oz8, ez);
`ifdef LOG2_EXACT_EN
      chk("exact8", ox8, (x != 0) && ((x & (x - 8'd1)) == 0));
`endif
      @(negedge clk);
      or8 = 1'b1;
      @(posedge clk);
      #1 or8 = 1'b0;
      chk("drain8", ov8, 0);
   endtask

   task automatic op32(input logic [31:0] x, input logic [5:0] ed, input logic ez, input int el);
      int lat;
      @(negedge clk);
      iv32 = 1'b1;
      id32 = x;
      #1 chk("in_ready32", ir32, 1);
      @(posedge clk);
      lat = 1;
      #1 iv32 = 1'b0;
      while (!ov32 && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("lat32", lat, el);
      chk("data32", od32, ed);
      chk("zero32", oz32, ez);
`ifdef LOG2_EXACT_EN
      chk("exact32", ox32, (x != 0) && ((x & (x - 32'd1)) == 0));
`endif
      @(negedge clk);
      or32 = 1'b1;
      @(posedge clk);
      #1 or32 = 1'b0;
      chk("drain32", ov32, 0);
   endtask

   initial begin
      logic [6:0] q[$];
      int         lat;
      int         nres;
      logic       acc;

      iv8 = 1'b0; or8 = 1'b0; id8 = '0;
      iv32 = 1'b0; or32 = 1'b0; id32 = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready8", ir8, 1);
      chk("rst_valid8", ov8, 0);
      chk("rst_data8", od8, 0);
      chk("rst_zero8", oz8, 0);
      chk("rst_valid32", ov32, 0);
`ifdef LOG2_EXACT_EN
      chk("rst_exact8", ox8, 0);
`endif
      @(negedge clk) rst_n = 1'b1;

      // reset in the middle of a search
      @(negedge clk);
      iv8 = 1'b1;
      id8 = 8'h40;
      @(posedge clk);
      #1 iv8 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_valid", ov8, 0);
      chk("midrst_ready", ir8, 1);
      @(negedge clk) rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("midrst_novalid", ov8, 0);
      end
      chk("midrst_ready_after", ir8, 1);

      // W=8 one-hot sweep, zero, non-one-hot
      for (int i = 0; i < 8; i++) op8(8'(1 << i), 4'(i), 1'b0, 4);
      op8(8'h00, 4'hF, 1'b1, 1);
      op8(8'h60, 4'd6, 1'b0, 4);
      op8(8'hFF, 4'd7, 1'b0, 4);
      op8(8'h03, 4'd1, 1'b0, 4);

      // W=32
      op32(32'h0000_6000, 6'd14, 1'b0, 6);
      op32(32'h8000_0000, 6'd31, 1'b0, 6);
      op32(32'h0000_0001, 6'd0,  1'b0, 6);
      op32(32'h0000_0000, 6'h3F, 1'b1, 1);
      op32(32'hFFFF_FFFF, 6'd31, 1'b0, 6);
      op32(32'h0001_0000, 6'd16, 1'b0, 6);

      // backpressure: result held while out_ready stays low
      @(negedge clk);
      iv8 = 1'b1;
      id8 = 8'h20;
      @(posedge clk);
      #1 iv8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("bp_lat", lat, 4);
      repeat (10) begin
         @(negedge clk);
         iv8 = 1'b1;
         id8 = 8'h01;
         #1;
         chk("bp_valid", ov8, 1);
         chk("bp_data", od8, 5);
         chk("bp_ready", ir8, 0);
      end
      @(negedge clk);
      iv8 = 1'b0;
      or8 = 1'b1;
      @(posedge clk);
      #1 or8 = 1'b0;
      chk("bp_drain", ov8, 0);
      repeat (6) begin
         @(negedge clk);
         chk("bp_ignored", ov8, 0);
      end
      chk("bp_ready_after", ir8, 1);

      // random operands with random handshakes on both sides
      nres = 0;
      acc = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (acc) iv32 = 1'b0;
         if (!iv32 && $urandom_range(0, 2) != 0) begin
            iv32 = 1'b1;
            id32 = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom() >> $urandom_range(0, 31));
         end
         or32 = 1'($urandom_range(0, 1));
         #1;
         acc = iv32 && ir32;
         if (acc) q.push_back(model32(id32));
         if (ov32 && or32) begin
            chk("rand_pending", q.size(), 1);
            if (q.size() > 0) begin
               chk("rand_res", {oz32, od32}, q.pop_front());
               nres++;
            end
         end
      end
      chk("rand_count_ok", nres >= 50, 1);
      iv32 = 1'b0;
      or32 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
